// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave block.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = $clog2(SPI_BYTE_W);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input, with a selectable reset level.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) ff_q <= {STAGES{RST_VAL}};
    else         ff_q <= {ff_q[STAGES-2:0], d_i};
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-3 SPI byte slave oversampled by clk_i, with a single-entry tx holding register.
module spi_slave
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_cs_n_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  input  logic [SPI_BYTE_W-1:0] tx_byte_i,
  input  logic                  tx_load_i,
  output logic                  tx_ready_o,
  output logic [SPI_BYTE_W-1:0] rx_byte_o,
  output logic                  rx_valid_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  // Bit order of the synchronized bundle: {mosi, cs_n, sclk}; bus idles high
  localparam logic [2:0] SYNC_RST = 3'b011;

  logic [2:0] async_in, sync_out;
  logic       sclk_s, cs_s, mosi_s;

  assign async_in = {spi_mosi_i, spi_cs_n_i, spi_clk_i};

  for (genvar g = 0; g < 3; g++) begin : g_sync
    spi_sync #(
      .STAGES (SYNC_STAGES),
      .RST_VAL(SYNC_RST[g])
    ) u_sync (
      .clk_i (clk_i),
      .rstn_i(rstn_i),
      .d_i   (async_in[g]),
      .q_o   (sync_out[g])
    );
  end

  assign sclk_s = sync_out[0];
  assign cs_s   = sync_out[1];
  assign mosi_s = sync_out[2];

  spi_state_e            state_q, state_d;
  logic                  sclk_q;
  logic [SPI_CNT_W-1:0]  cnt_q;
  logic [SPI_BYTE_W-1:0] rx_sr_q, rx_byte_q, tx_sr_q, hold_q;
  logic                  full_q, done_q, rx_valid_q, urun_q;

  logic start, stop, active, rise_en, fall_en, last_bit;
  logic reload, consume, load_ok;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!cs_s) state_d = SHIFT;
      SHIFT:   if (cs_s)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign start    = (state_q == IDLE) && !cs_s;
  assign stop     = (state_q == SHIFT) && cs_s;
  assign active   = (state_q == SHIFT) && !cs_s;
  assign rise_en  = active && sclk_s && !sclk_q;
  assign fall_en  = active && !sclk_s && sclk_q;
  assign last_bit = rise_en && (cnt_q == '1);

  // Byte boundary: chip-select fall, or the first fall after a full byte
  assign reload  = start || (fall_en && done_q);
  assign consume = reload && full_q;
  // A load landing on the consume cycle refills the register straight away
  assign load_ok = tx_load_i && (!full_q || consume);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      sclk_q     <= 1'b1;
      cnt_q      <= '0;
      rx_sr_q    <= '0;
      rx_byte_q  <= '0;
      tx_sr_q    <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      urun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sclk_q     <= sclk_s;
      rx_valid_q <= last_bit;
      urun_q     <= reload && !full_q;

      if (load_ok) begin
        full_q <= 1'b1;
        hold_q <= tx_byte_i;
      end else if (consume) begin
        full_q <= 1'b0;
      end

      if (stop) begin
        cnt_q   <= '0;
        rx_sr_q <= '0;
      end else if (rise_en) begin
        cnt_q   <= cnt_q + 1'b1;
        rx_sr_q <= {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
        if (cnt_q == '1) rx_byte_q <= {rx_sr_q[SPI_BYTE_W-2:0], mosi_s};
      end

      if (stop)          done_q <= 1'b0;
      else if (last_bit) done_q <= 1'b1;
      else if (fall_en)  done_q <= 1'b0;

      // Bit 7 is already on the line at the boundary, so the opening fall of a
      // byte (count still zero, no byte pending) leaves the register alone
      if (reload)                       tx_sr_q <= full_q ? hold_q : '0;
      else if (fall_en && cnt_q != '0)  tx_sr_q <= {tx_sr_q[SPI_BYTE_W-2:0], 1'b0};
    end
  end

  assign spi_miso_o    = (state_q == SHIFT) ? tx_sr_q[SPI_BYTE_W-1] : IDLE_MISO;
  assign spi_miso_oe_o = active;
  assign busy_o        = (state_q == SHIFT);
  assign tx_ready_o    = !full_q;
  assign rx_byte_o     = rx_byte_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_underrun_o = urun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Randomized bench for spi_slave: a master task drives mode-3 transfers, a byte-level model predicts MISO/underruns.
module tb_spi_slave;

  localparam int SS   = 2;
  localparam int HMIN = SS + 2;

  logic       clk_i = 1'b0;
  logic       rstn_i = 1'b0;
  logic       spi_clk_i = 1'b1;
  logic       spi_cs_n_i = 1'b1;
  logic       spi_mosi_i = 1'b0;
  logic       tx_load_i = 1'b0;
  logic [7:0] tx_byte_i = 8'h00;
  logic       spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_valid_o, tx_underrun_o, busy_o;
  logic [7:0] rx_byte_o;

  always #5 clk_i = ~clk_i;

  spi_slave #(.SYNC_STAGES(SS), .IDLE_MISO(1'b1)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .spi_clk_i    (spi_clk_i),
    .spi_cs_n_i   (spi_cs_n_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_miso_o   (spi_miso_o),
    .spi_miso_oe_o(spi_miso_oe_o),
    .tx_byte_i    (tx_byte_i),
    .tx_load_i    (tx_load_i),
    .tx_ready_o   (tx_ready_o),
    .rx_byte_o    (rx_byte_o),
    .rx_valid_o   (rx_valid_o),
    .tx_underrun_o(tx_underrun_o),
    .busy_o       (busy_o)
  );

  int n_chk = 0, n_err = 0;
  int rxv_cnt = 0, urun_cnt = 0, rdy_hi = 0;
  int exp_rxv = 0, exp_urun = 0;
  logic       win = 1'b0, hold_load = 1'b0;
  logic       exp_full = 1'b0;
  logic [7:0] exp_hold = 8'h00;
  logic [7:0] mosi_b[256], ld_val[256], exp_miso[256];
  logic       ld_en[256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rx_valid_o) rxv_cnt++;
    if (tx_underrun_o) urun_cnt++;
    if (win && tx_ready_o) rdy_hi++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Reference model: one-entry holding register seen at byte granularity
  task automatic m_load(input logic [7:0] v);
    if (!exp_full) begin
      exp_full = 1'b1;
      exp_hold = v;
    end
  endtask

  task automatic m_bound(output logic [7:0] e);
    if (exp_full) begin
      e = exp_hold;
      exp_full = 1'b0;
    end else begin
      e = 8'h00;
      exp_urun++;
    end
  endtask

  task automatic tb_load(input logic [7:0] v);
    tx_byte_i = v;
    tx_load_i = 1'b1;
    tick(1);
    tx_load_i = 1'b0;
    m_load(v);
  endtask

  // nb bytes at half-period h; cut>0 truncates the last byte, rst_cut resets instead of raising cs
  task automatic xfer(input int nb, input int h, input int cut, input bit rst_cut);
    logic [7:0] sh;
    int bits;
    sh = 8'h00;
    spi_cs_n_i = 1'b0;
    m_bound(exp_miso[0]);
    tick(2 * h);
    if (hold_load) begin
      tx_load_i = 1'b0;
      hold_load = 1'b0;
      m_load(tx_byte_i);
    end
    for (int b = 0; b < nb; b++) begin
      bits = (cut > 0 && b == nb - 1) ? cut : 8;
      if (b > 0) begin
        win = 1'b0;
        m_bound(exp_miso[b]);
      end
      for (int i = 7; i >= 8 - bits; i--) begin
        spi_clk_i  = 1'b0;
        spi_mosi_i = mosi_b[b][i];
        if (i == 4 && ld_en[b]) begin
          tx_byte_i = ld_val[b];
          tx_load_i = 1'b1;
          tick(1);
          tx_load_i = 1'b0;
          m_load(ld_val[b]);
          tick(h - 1);
        end else begin
          tick(h);
        end
        if (i == 7) chk("miso_oe_active", spi_miso_oe_o, 1);
        sh = {sh[6:0], spi_miso_o};
        spi_clk_i = 1'b1;
        tick(h);
      end
      if (bits == 8) begin
        chk("miso_byte", sh, exp_miso[b]);
        chk("rx_byte", rx_byte_o, mosi_b[b]);
        exp_rxv++;
        chk("rx_valid_cnt", rxv_cnt, exp_rxv);
      end
    end
    if (rst_cut) begin
      #2 rstn_i = 1'b0;
      #1;
      chk("rst_miso", spi_miso_o, 1);
      chk("rst_oe", spi_miso_oe_o, 0);
      chk("rst_ready", tx_ready_o, 1);
      chk("rst_rx_byte", rx_byte_o, 8'h00);
      chk("rst_rx_valid", rx_valid_o, 0);
      chk("rst_underrun", tx_underrun_o, 0);
      chk("rst_busy", busy_o, 0);
      spi_cs_n_i = 1'b1;
      spi_clk_i  = 1'b1;
      tick(3);
      rstn_i   = 1'b1;
      exp_full = 1'b0;
      tick(2);
    end else begin
      spi_cs_n_i = 1'b1;
      tick(2 * h);
    end
    chk("rx_valid_total", rxv_cnt, exp_rxv);
    chk("underrun_total", urun_cnt, exp_urun);
    chk("idle_miso", spi_miso_o, 1);
    chk("idle_oe", spi_miso_oe_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("tx_ready", tx_ready_o, !exp_full);
  endtask

  initial begin
    int r0;
    for (int i = 0; i < 256; i++) begin
      mosi_b[i] = 8'h00;
      ld_val[i] = 8'h00;
      ld_en[i]  = 1'b0;
    end

    tick(3);
    chk("reset_miso", spi_miso_o, 1);
    chk("reset_oe", spi_miso_oe_o, 0);
    chk("reset_ready", tx_ready_o, 1);
    chk("reset_rx_byte", rx_byte_o, 8'h00);
    chk("reset_rx_valid", rx_valid_o, 0);
    chk("reset_underrun", tx_underrun_o, 0);
    chk("reset_busy", busy_o, 0);
    rstn_i = 1'b1;
    tick(2);

    // Single byte; second load is ignored while full
    tb_load(8'hA5);
    chk("ready_after_load", tx_ready_o, 0);
    tb_load(8'h5A);
    mosi_b[0] = 8'h3C;
    xfer(1, 6, 0, 0);

    // Three-byte burst, second byte loaded mid-way through the first
    tb_load(8'h11);
    mosi_b[0] = 8'hC1; mosi_b[1] = 8'h5E; mosi_b[2] = 8'h99;
    ld_en[0] = 1'b1; ld_val[0] = 8'h22;
    xfer(3, 6, 0, 0);

    // Aborted byte keeps the load it received; next full byte is clean
    mosi_b[0] = 8'hF0; ld_val[0] = 8'h6B;
    xfer(1, 6, 5, 0);
    ld_en[0] = 1'b0;
    mosi_b[0] = 8'hC3;
    xfer(1, 6, 0, 0);

    // Load held across the consume at chip-select fall
    tb_load(8'h55);
    tx_byte_i = 8'h77;
    tx_load_i = 1'b1;
    hold_load = 1'b1;
    r0  = rdy_hi;
    win = 1'b1;
    mosi_b[0] = 8'h0F; mosi_b[1] = 8'hAB;
    xfer(2, 6, 0, 0);
    win = 1'b0;
    chk("ready_low_on_refill", rdy_hi - r0, 0);

    // Reset mid-byte with the holding register full
    mosi_b[0] = 8'hE7; ld_en[0] = 1'b1; ld_val[0] = 8'h9C;
    xfer(1, HMIN, 5, 1);
    ld_en[0] = 1'b0;

    // Minimum half-period, random data and random loads
    for (int i = 0; i < 256; i++) begin
      mosi_b[i] = 8'($urandom_range(0, 255));
      ld_en[i]  = 1'($urandom_range(0, 1));
      ld_val[i] = 8'($urandom_range(0, 255));
    end
    xfer(256, HMIN, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
